// File: rtl/burst_mem_responder_if.sv
// burst_mem_responder_if: 64-bit burst physical-memory bus between initiator and responder
interface burst_mem_responder_if;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic        pmem_resp;
  logic [63:0] pmem_rdata;
  logic        proto_err;
  modport master(output pmem_read, pmem_write, pmem_address, pmem_wdata, input pmem_resp, pmem_rdata, proto_err);
  modport slave(input pmem_read, pmem_write, pmem_address, pmem_wdata, output pmem_resp, pmem_rdata, proto_err);
endinterface

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: line-organised backing store answering 4-beat bursts after a fixed latency
module burst_mem_responder #(
  parameter int LINES   = 256,
  parameter int LATENCY = 8
) (
  input logic                  clk,
  input logic                  rst,
  burst_mem_responder_if.slave bus
);
  localparam int IW = $clog2(LINES);
  typedef enum logic [1:0] {IDLE, WAIT, BURST, RECOVER} state_t;
  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic          op_rd, op_rd_n, err_n, resp_n, we, idle, req, held, burst, unused_ok;
  logic [7:0]    lat_cnt, lat_n;
  logic [1:0]    beat, beat_n;
  logic [63:0]   rdata_n;
  logic [63:0]   mem [LINES*4];
  assign req       = bus.pmem_read | bus.pmem_write;
  assign held      = op_rd ? bus.pmem_read : bus.pmem_write;
  assign unused_ok = ^bus.pmem_address;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      op_rd          <= 1'b0;
      lat_cnt        <= '0;
      beat           <= '0;
      bus.pmem_resp  <= 1'b0;
      bus.pmem_rdata <= '0;
      bus.proto_err  <= 1'b0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      op_rd          <= op_rd_n;
      lat_cnt        <= lat_n;
      beat           <= beat_n;
      bus.pmem_resp  <= resp_n;
      bus.pmem_rdata <= rdata_n;
      bus.proto_err  <= err_n;
    end
  // a dropped request during WAIT/BURST aborts straight back to IDLE
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req ? (LATENCY == 0 ? BURST : WAIT) : IDLE;
      WAIT:    state_n = !held ? IDLE : (lat_cnt == 8'd1 ? BURST : WAIT);
      BURST:   state_n = !held ? IDLE : (bus.pmem_resp && beat == 2'd3 ? RECOVER : BURST);
      default: state_n = IDLE;
    endcase
  end
  // first BURST cycle only primes beat 0; resp rises one edge later
  always_comb begin
    idle    = state == IDLE;
    idx_n   = idle && req ? bus.pmem_address[5 +: IW] : idx;
    op_rd_n = idle && req ? bus.pmem_read : op_rd;
    lat_n   = idle ? 8'(LATENCY) : (state == WAIT ? lat_cnt - 8'd1 : lat_cnt);
    burst   = state == BURST && held;
    resp_n  = burst && !(bus.pmem_resp && beat == 2'd3);
    beat_n  = burst && bus.pmem_resp ? beat + 2'd1 : 2'd0;
    rdata_n = resp_n ? mem[{idx, beat_n}] : '0;
    we      = burst && bus.pmem_resp && !op_rd;
    err_n   = bus.proto_err | (idle && bus.pmem_read && bus.pmem_write) | ((state == WAIT || state == BURST) && !held);
  end
  always_ff @(posedge clk)
    if (we) mem[{idx, beat}] <= bus.pmem_wdata;
endmodule
